// File: rtl/fetch_buffer_pkg.sv
// Shared core constants for the fetch/decode boundary.
package fetch_buffer_pkg;

  localparam int unsigned FETCH_DATA_WIDTH    = 32;
  localparam int unsigned FETCH_ADDRESS_BITS  = 20;
  localparam int unsigned FETCH_PACKET_WIDTH  = FETCH_DATA_WIDTH + FETCH_ADDRESS_BITS;
  localparam int unsigned FETCH_DEFAULT_DEPTH = 4;

endpackage

// File: rtl/fetch_buffer.sv
// Circular instruction buffer between fetch and decode.
// Optional same-cycle empty-buffer bypass: define FETCH_BUFFER_BYPASS_EN.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int          CORE         = 0,
  parameter int unsigned DATA_WIDTH   = FETCH_DATA_WIDTH,
  parameter int unsigned ADDRESS_BITS = FETCH_ADDRESS_BITS,
  parameter int unsigned DEPTH        = FETCH_DEFAULT_DEPTH
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  input  logic [DATA_WIDTH-1:0]     in_instruction,
  input  logic [ADDRESS_BITS-1:0]   in_PC,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [DATA_WIDTH-1:0]     out_instruction,
  output logic [ADDRESS_BITS-1:0]   out_PC,
  input  logic                      out_ready,
  output logic [$clog2(DEPTH):0]    count,
  input  logic                      report
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned PKT_W = DATA_WIDTH + ADDRESS_BITS;

  logic [PKT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             started;
  logic [31:0]      cycle_cnt;

  logic             empty;
  logic             bypass;
  logic             push;
  logic             pop;
  logic [PKT_W-1:0] head;

  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Handshakes; started keeps in_ready low until the first edge after reset.
  always_comb begin
    bypass          = 1'b0;
    in_ready        = started && (count < CNT_W'(DEPTH)) && !flush;
    out_valid       = started && !empty && !flush;
    out_instruction = head[PKT_W-1:ADDRESS_BITS];
    out_PC          = head[ADDRESS_BITS-1:0];
`ifdef FETCH_BUFFER_BYPASS_EN
    bypass = started && empty && in_valid && !flush;
    if (bypass) begin
      out_valid       = 1'b1;
      out_instruction = in_instruction;
      out_PC          = in_PC;
    end
`endif
    // A bypassed word consumed this cycle is never stored.
    push = in_valid && in_ready && !(bypass && out_ready);
    pop  = out_valid && out_ready && !bypass;
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= {in_instruction, in_PC};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      started   <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      started   <= 1'b1;
      cycle_cnt <= cycle_cnt + 32'(1);
      if (flush) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop)      count <= count + CNT_W'(1);
        else if (pop && !push) count <= count - CNT_W'(1);
      end
      if (report) begin
        $display("fetch_buffer core %0d cycle %0d count %0d rd %0d wr %0d in %b/%b out %b/%b",
                 CORE, cycle_cnt, count, rd_ptr, wr_ptr, in_valid, in_ready, out_valid, out_ready);
      end
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Scoreboard bench for fetch_buffer; honours FETCH_BUFFER_BYPASS_EN.
module tb_fetch_buffer;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 20;
  localparam int unsigned DEPTH = 4;
`ifdef FETCH_BUFFER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_instruction = '0;
  logic [AW-1:0] in_PC = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_instruction;
  logic [AW-1:0] out_PC;
  logic          out_ready = 1'b0;
  logic [2:0]    count;
  logic          report = 1'b0;

  fetch_buffer #(.CORE(0), .DATA_WIDTH(DW), .ADDRESS_BITS(AW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_instruction(in_instruction), .in_PC(in_PC), .in_ready(in_ready),
    .out_valid(out_valid), .out_instruction(out_instruction), .out_PC(out_PC),
    .out_ready(out_ready), .count(count), .report(report)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic [DW+AW-1:0] sb[$];
  int  mcount   = 0;
  bit  mstarted = 1'b0;
  int  maxcount = 0;
  bit  seen40   = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: check at negedge against the model, update model, advance past posedge.
  task automatic step();
    bit exp_in_ready, exp_out_valid, byp, do_push, do_pop;
    logic [DW+AW-1:0] exp_head;
    @(negedge clock);
    exp_in_ready  = mstarted && (mcount < DEPTH) && !flush;
    byp           = BYP && mstarted && (mcount == 0) && in_valid && !flush;
    exp_out_valid = mstarted && !flush && ((mcount != 0) || byp);
    check("in_ready", 64'(in_ready), 64'(exp_in_ready));
    check("out_valid", 64'(out_valid), 64'(exp_out_valid));
    check("count", 64'(count), 64'(mcount));
    if (exp_out_valid) begin
      exp_head = byp ? {in_instruction, in_PC} : sb[0];
      check("out_PC", 64'(out_PC), 64'(exp_head[AW-1:0]));
      check("out_instruction", 64'(out_instruction), 64'(exp_head[DW+AW-1:AW]));
      if (out_PC == AW'('h40)) seen40 = 1'b1;
    end
    do_pop  = exp_out_valid && out_ready && !byp;
    do_push = in_valid && exp_in_ready && !(byp && out_ready);
    if (flush) begin
      sb.delete();
      mcount = 0;
    end else begin
      if (do_pop)  begin void'(sb.pop_front()); mcount--; end
      if (do_push) begin sb.push_back({in_instruction, in_PC}); mcount++; end
    end
    if (mcount > maxcount) maxcount = mcount;
    @(posedge clock);
    #1;
    mstarted = !reset;
  endtask

  task automatic drive(input bit v, input logic [AW-1:0] pc, input bit rdy);
    in_valid       = v;
    in_PC          = pc;
    in_instruction = $urandom();
    out_ready      = rdy;
    step();
  endtask

  task automatic drain();
    for (int i = 0; i < 8; i++) drive(1'b0, '0, 1'b1);
    check("drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    reset = 1'b0;

    // Fill three with decode stalled.
    drive(1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, AW'(i * 4), 1'b0);
    drive(1'b0, '0, 1'b0);
    check("fill3_count", 64'(count), 64'd3);
    check("fill3_head", 64'(out_PC), 64'h0);

    // Fill to full; a fifth word is refused.
    drive(1'b1, AW'('h0C), 1'b0);
    drive(1'b1, AW'('h10), 1'b0);
    check("full_count", 64'(count), 64'd4);
    check("full_in_ready", 64'(in_ready), 64'd0);
    drain();

    // Ten pushes with continuous pops across pointer wrap.
    maxcount = 0;
    for (int i = 0; i < 10; i++) drive(1'b1, AW'(i * 4), 1'b1);
    drain();
    check("stream_maxcount", 64'(maxcount <= 1), 64'd1);

    // Flush with a concurrent offered word.
    for (int i = 0; i < 3; i++) drive(1'b1, AW'('h20 + i * 4), 1'b0);
    flush = 1'b1;
    drive(1'b1, AW'('h40), 1'b0);
    flush = 1'b0;
    drive(1'b0, '0, 1'b0);
    check("flush_count", 64'(count), 64'd0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    drain();
    check("flush_no_0x40", 64'(seen40), 64'd0);

    // Asynchronous mid-stream reset.
    for (int i = 0; i < 2; i++) drive(1'b1, AW'('h50 + i * 4), 1'b0);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_count", 64'(count), 64'd0);
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    sb.delete();
    mcount   = 0;
    mstarted = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    drive(1'b1, AW'('h60), 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b1, AW'('h64 + i * 4), 1'b0);
    drain();

`ifdef FETCH_BUFFER_BYPASS_EN
    drive(1'b1, AW'('h100), 1'b1);
    check("bypass_count", 64'(count), 64'd0);
    drive(1'b1, AW'('h104), 1'b0);
    drain();
`endif

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 300; i++) begin
      flush = ($urandom_range(0, 19) == 0);
      drive(1'($urandom_range(0, 1)), AW'($urandom()), 1'($urandom_range(0, 1)));
    end
    flush = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have parameter CORE, default 0, core index printed in report output.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, instruction width.
REQ-003 SHALL have parameter ADDRESS_BITS, default 20, PC width.
REQ-004 SHALL have parameter DEPTH, default 4, entry count; power of two, at least 2.
REQ-005 SHALL have port clock  input  1  sole clock, rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port flush  input  1  pipeline redirect (JAL/JALR/taken branch/accel interrupt); discards all entries.
REQ-008 SHALL have port in_valid  input  1  fetch stage offers an instruction.
REQ-009 SHALL have port in_instruction  input  DATA_WIDTH  fetched instruction word.
REQ-010 SHALL have port in_PC  input  ADDRESS_BITS  byte address of the fetched instruction.
REQ-011 SHALL have port in_ready  output  1  buffer accepts an instruction this cycle.
REQ-012 SHALL have port out_valid  output  1  head entry available to decode.
REQ-013 SHALL have port out_instruction  output  DATA_WIDTH  head instruction.
REQ-014 SHALL have port out_PC  output  ADDRESS_BITS  head PC.
REQ-015 SHALL have port out_ready  input  1  decode consumes the head this cycle.
REQ-016 SHALL have port count  output  clog2(DEPTH)+1  stored entry count.
REQ-017 SHALL have port report  input  1  print state via $display on the clock edge.

Function
REQ-018 SHALL store {instruction, PC} in a DEPTH-entry circular array with read/write pointers wrapping modulo DEPTH.
REQ-019 SHALL push on clock edge when in_valid && in_ready && !flush.
REQ-020 SHALL pop on clock edge when out_valid && out_ready && !flush.
REQ-021 SHALL drive in_ready = (count < DEPTH) && !flush; no push while full, even with a simultaneous pop.
REQ-022 SHALL drive out_valid = (count != 0) && !flush; out_instruction/out_PC show the head entry combinationally.
REQ-023 SHALL give a minimum latency of one cycle from push to out_valid when bypass is absent.
REQ-024 SHALL leave count unchanged on a simultaneous push and pop; otherwise count SHALL change by exactly +1 or -1.
REQ-025 SHALL, on flush, zero count and both pointers at the next edge, drop any concurrent push and pop, and ignore in_valid in that cycle.
REQ-026 SHALL preserve entry order exactly across pointer wrap-around.
REQ-027 SHALL keep out_instruction and out_PC stable while out_valid && !out_ready.
REQ-028 SHALL, while report is high, $display CORE, a cycle counter, count, both pointers, and both handshakes.

Reset
REQ-029 SHALL, on asserted reset, set count=0, pointers=0, out_valid=0, in_ready=0, and the cycle counter to 0, independent of clock.
REQ-030 SHALL, on mid-operation reset, discard all stored entries; the array contents need not be cleared.
REQ-031 SHALL raise in_ready on the first edge after reset deassertion.

Configuration
REQ-032 SHALL honour the macro FETCH_BUFFER_BYPASS_EN.
REQ-033 SHALL, with FETCH_BUFFER_BYPASS_EN defined, when count==0 && in_valid && !flush, drive out_valid=1 and out_instruction/out_PC=in_instruction/in_PC in the same cycle.
REQ-034 SHALL, in that bypass case, not store the word if out_ready=1, and store it normally if out_ready=0.
REQ-035 SHALL, without FETCH_BUFFER_BYPASS_EN, provide no combinational in-to-out path.

Structure
REQ-036 SHALL place the fetch-packet width (DATA_WIDTH+ADDRESS_BITS) and the default DEPTH constant in the shared core package for reuse by decode.
REQ-037 SHALL implement storage inline; no sub-module is required.

Verification
REQ-038 Reset then push PCs 0x00,0x04,0x08 with out_ready=0 -> count=3; out_PC=0x00; in_ready=1.
REQ-039 Fill 4 entries with out_ready=0 -> in_ready=0 and count=4; a 5th in_valid word (PC 0x10) is not accepted.
REQ-040 Run 10 pushes with continuous pops, DEPTH=4 -> out_PC sequence is 0x00..0x24 in order across wrap; count never exceeds 1.
REQ-041 With 3 entries, assert flush with in_valid (PC 0x40) -> next cycle count=0 and out_valid=0; PC 0x40 is never output.
REQ-042 Assert reset asynchronously mid-stream with count=2 -> count=0 and out_valid=0 before the next edge.
REQ-043 FETCH_BUFFER_BYPASS_EN, empty, in_PC=0x100, out_ready=1 -> out_valid=1 and out_PC=0x100 in the same cycle; count stays 0.
